// File: rtl/sample_buf_reader.sv
// sample_buf_reader
// Reads a 2**AW-word sample buffer from address 0 to 2**AW-1 once per
// accepted start and streams the words out over a valid/ready port. A
// two-entry output buffer absorbs downstream back-pressure. Reads are issued
// only while the buffer plus outstanding reads can still take the returning
// word.
//
// Optional feature: define SAMPLE_BUF_READER_CHKSUM_EN to append one extra
// word after the last sample. That word is the modulo-2**DW sum of all
// transferred samples, and it carries out_last.
module sample_buf_reader #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          buf_full,
  output logic [AW-1:0] r_addr,
  output logic          rden,
  input  logic [DW-1:0] r_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          final_xfer;
  logic          fifo_pop;
  logic [2:0]    occ_nxt;
  logic          in_flight;
  logic          in_flight_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          fifo_valid;
  logic [DW-1:0] head_data;
  logic          head_last;

  assign accept     = (state == IDLE) && start && buf_full;
  assign fifo_valid = (fifo_cnt != 2'd0);
  assign head_data  = fifo_data[rd_ptr];
  assign head_last  = fifo_last[rd_ptr];
  assign fifo_pop   = fifo_valid && out_ready;

  // Words that will be buffered or in flight after this edge if no new read is issued.
  assign occ_nxt = 3'(fifo_cnt) + 3'(in_flight) - 3'(fifo_pop);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: registers take non-blocking assignments. Every flop then samples
    // pre-edge values, whatever order the blocks are evaluated in.
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, leave READ after the last address is issued.
  always_comb begin
    // NOTE: assign a default before the case. Every path then writes
    // state_nxt, and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                       state_nxt = READ;
      READ:    if (rden && r_addr == LAST_ADDR)  state_nxt = DRAIN;
      DRAIN:   if (final_xfer)                   state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy for the whole readout. Read only while there is room for the returning word.
  always_comb begin
    busy = (state != IDLE);
    rden = (state == READ) && (occ_nxt <= 3'd1);
  end

  // Read address, read-return tracking and the done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr         <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (accept)                           r_addr <= '0;
      else if (rden && r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
      in_flight      <= rden;
      in_flight_last <= rden && (r_addr == LAST_ADDR);
      done           <= final_xfer;
    end
  end

  // Two-entry in-order output buffer. Data returns one cycle after rden.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the two storage words are reset on purpose. out_data shows the
      // head entry and must read 0 while in reset. Larger RAM-style storage
      // would normally be left unreset.
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (in_flight) begin
        fifo_data[wr_ptr] <= r_data;
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({in_flight, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef SAMPLE_BUF_READER_CHKSUM_EN
  logic [DW-1:0] chk_sum;
  logic          chk_valid;

  // Running sum of transferred samples. The checksum word is presented once the last sample has left.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chk_sum   <= '0;
      chk_valid <= 1'b0;
    end else begin
      if (accept)        chk_sum <= '0;
      else if (fifo_pop) chk_sum <= chk_sum + head_data;
      if (fifo_pop && head_last)       chk_valid <= 1'b1;
      else if (chk_valid && out_ready) chk_valid <= 1'b0;
    end
  end

  assign out_valid  = fifo_valid || chk_valid;
  assign out_data   = chk_valid ? chk_sum : head_data;
  assign out_last   = chk_valid;
  assign final_xfer = chk_valid && out_ready;
`else
  assign out_valid  = fifo_valid;
  assign out_data   = head_data;
  assign out_last   = fifo_valid && head_last;
  assign final_xfer = fifo_pop && head_last;
`endif

endmodule

// File: tb/tb_sample_buf_reader.sv
// Testbench for sample_buf_reader. A synchronous-read buffer model feeds
// r_data. The bench keeps its own view of the readout: the expected word
// stream, counts of reads issued and words transferred, and the expected
// busy/done. It checks every output on each cycle against that view.
`timescale 1ns/1ps
module tb_sample_buf_reader;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef SAMPLE_BUF_READER_CHKSUM_EN
  localparam int          TOTAL         = DEPTH + 1;
  localparam logic [31:0] LAST_WORD_EXP = 32'h0001_FF00;
`else
  localparam int          TOTAL         = DEPTH;
  localparam logic [31:0] LAST_WORD_EXP = 32'd511;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          buf_full;
  logic [AW-1:0] r_addr;
  logic          rden;
  logic [DW-1:0] r_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  // Bench view of the readout.
  bit            m_active        = 1'b0;
  bit            m_done_exp      = 1'b0;
  bit            m_first_pending = 1'b0;
  bit            prev_stall      = 1'b0;
  logic [DW-1:0] prev_data       = '0;
  int            m_idx           = 0;
  int            m_issued        = 0;
  int            cyc             = 0;
  int            accept_cyc      = 0;
  int            first_valid_cyc = 0;
  int            final_xfer_cyc  = 0;
  int            xfer_count      = 0;
  int            rden_count      = 0;
  logic [DW-1:0] first_word      = '0;
  logic [DW-1:0] final_word      = '0;
  bit            c_xfer;
  bit            c_fin;
  bit            c_acc;

  sample_buf_reader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .buf_full  (buf_full),
    .r_addr    (r_addr),
    .rden      (rden),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read sample buffer: data appears the cycle after rden.
  always @(posedge clk) if (rden) r_data <= mem[r_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word at stream position idx: the samples in order, then their sum.
  function automatic logic [DW-1:0] expected_word(input int idx);
    logic [DW-1:0] s;
    s = '0;
    if (idx < DEPTH) return mem[idx];
    for (int i = 0; i < DEPTH; i++) s = s + mem[i];
    return s;
  endfunction

  // Compare process: inputs change on the falling edge and outputs are sampled 1ns later.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rden) rden_count++;
    if (!n_rst) begin
      check("rst_r_addr", r_addr, 0);
      check("rst_rden", rden, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_data", out_data, 0);
      m_active        = 1'b0;
      m_done_exp      = 1'b0;
      m_first_pending = 1'b0;
      prev_stall      = 1'b0;
    end else begin
      check("busy", busy, m_active);
      check("done", done, m_done_exp);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (!m_active) begin
        check("idle_rden", rden, 0);
        check("idle_out_valid", out_valid, 0);
      end else begin
        if (rden) begin
          check("r_addr", r_addr, m_issued);
          check("rden_occupancy",
                (m_issued - m_idx - ((out_valid && out_ready) ? 1 : 0)) <= 1, 1);
        end
        if (out_valid) begin
          if (m_first_pending) begin
            check("first_valid_latency", cyc - accept_cyc, 3);
            m_first_pending = 1'b0;
            first_valid_cyc = cyc;
          end
          check("out_data", out_data, expected_word(m_idx));
          check("out_last", out_last, m_idx == TOTAL - 1);
        end
      end
      // Work out what the coming rising edge does.
      c_xfer     = m_active && out_valid && out_ready;
      c_fin      = c_xfer && (m_idx == TOTAL - 1);
      c_acc      = !m_active && start && buf_full;
      prev_stall = m_active && out_valid && !out_ready;
      prev_data  = out_data;
      if (c_xfer) begin
        if (m_idx == 0) first_word = out_data;
        m_idx++;
        xfer_count++;
      end
      if (m_active && rden) m_issued++;
      if (c_fin) begin
        m_active       = 1'b0;
        final_word     = out_data;
        final_xfer_cyc = cyc;
      end
      m_done_exp = c_fin;
      if (c_acc) begin
        m_active        = 1'b1;
        m_idx           = 0;
        m_issued        = 0;
        xfer_count      = 0;
        accept_cyc      = cyc;
        m_first_pending = 1'b1;
      end
    end
  end

  // One readout. rand_ready adds random back-pressure and ignored start/buf_full
  // noise. stall_at holds ready low for 10 cycles at that word. rst_at pulses
  // reset at that word.
  task automatic run_readout(input bit rand_ready, input int stall_at, input int rst_at,
                             input string tag);
    int stall_left = 0;
    bit stalled    = 1'b0;
    bit finished   = 1'b0;
    bit was_reset  = 1'b0;
    for (int c = 0; c < 8000 && !finished; c++) begin
      @(negedge clk);
      if (was_reset) begin
        n_rst    = 1'b1;
        finished = 1'b1;
      end else begin
        if (c == 0) begin
          start    = 1'b1;
          buf_full = 1'b1;
        end else if (rand_ready && m_active) begin
          start    = ($urandom_range(0, 7) == 0);
          buf_full = 1'($urandom_range(0, 1));
        end else begin
          start    = 1'b0;
          buf_full = 1'b1;
        end
        if (!stalled && m_active && m_idx == stall_at) begin
          stall_left = 10;
          stalled    = 1'b1;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rst_at >= 0 && m_active && m_idx == rst_at) begin
          n_rst     = 1'b0;
          start     = 1'b0;
          was_reset = 1'b1;
        end
        #2;
        if (!was_reset && done) finished = 1'b1;
      end
    end
    if (!finished) check({tag, "_timeout"}, 0, 1);
    start    = 1'b0;
    buf_full = 1'b1;
    n_rst    = 1'b1;
  endtask

  initial begin
    int rden_before;
    n_rst     = 1'b0;
    start     = 1'b0;
    buf_full  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // start with the buffer not full must be ignored.
    rden_before = rden_count;
    @(negedge clk);
    start     = 1'b1;
    buf_full  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("nofull_busy", busy, 0);
    check("nofull_rden_count", rden_count - rden_before, 0);

    // Ramp buffer, ready held high: back-to-back words 0..511.
    run_readout(1'b0, -1, -1, "ramp");
    check("ramp_first_word", first_word, 0);
    check("ramp_final_word", final_word, LAST_WORD_EXP);
    check("ramp_xfer_count", xfer_count, TOTAL);
    check("ramp_no_bubbles", final_xfer_cyc - first_valid_cyc, TOTAL - 1);
    check("model_word_511", expected_word(DEPTH - 1), 511);
    check("model_sum", expected_word(DEPTH), 32'h0001_FF00);

    // Same ramp with random back-pressure and a 10-cycle stall at word 100.
    repeat (3) @(negedge clk);
    run_readout(1'b1, 100, -1, "stall");
    check("stall_final_word", final_word, LAST_WORD_EXP);
    check("stall_xfer_count", xfer_count, TOTAL);

    // Random contents, reset pulsed at word 200, then a full restart.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    run_readout(1'b1, -1, 200, "abort");
    repeat (2) @(negedge clk);
    run_readout(1'b1, 50, -1, "restart");
    check("restart_first_word", first_word, mem[0]);
    check("restart_xfer_count", xfer_count, TOTAL);

    // Fresh random contents, ready held high.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    run_readout(1'b0, -1, -1, "rand_full");
    check("rand_full_final_word", final_word, expected_word(TOTAL - 1));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
